// File: rtl/jtag_spi_bridge_mc.sv
// jtag_spi_bridge_mc: user-DR scan chain to multi chip-select SPI master.
// Each DR scan carries a chip-select index header (LSB first) followed by the
// SPI payload, where every payload bit occupies two TCK cycles.
`timescale 1ns/1ps
module jtag_spi_bridge_mc #(
  parameter int   NUM_CS = 4,
  parameter logic CPOL   = 1'b1,
  parameter logic CPHA   = 1'b1,
  parameter int   CNT_W  = 16
) (
  input  logic              jtag_tck,
  input  logic              jtag_reset,
  input  logic              jtag_sel,
  input  logic              jtag_capture,
  input  logic              jtag_shift,
  input  logic              jtag_update,
  input  logic              jtag_tdi,
  output logic              jtag_tdo,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [CNT_W-1:0]  bit_count,
  output logic              busy
);
  localparam int SEL_BITS = $clog2(NUM_CS);
  localparam int HDR_W    = $clog2(SEL_BITS + 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

  state_t              state_reg, state_next;
  logic [NUM_CS-1:0]   cs_n_reg, cs_n_next;
  logic                clk_reg, clk_next;
  logic                mosi_reg, mosi_next;
  logic                tdo_reg, tdo_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                phase_reg, phase_next;
  logic [HDR_W-1:0]    hdr_cnt_reg, hdr_cnt_next;
  logic [SEL_BITS-1:0] cs_idx_reg, cs_idx_next;
  logic [SEL_BITS-1:0] idx_shifted;
  logic [NUM_CS-1:0]   cs_hit;
  logic                xfer_active;

  // Index value after shifting the current TDI bit in at the MSB end.
  always_comb begin
    idx_shifted = (cs_idx_reg >> 1) | (SEL_BITS'(jtag_tdi) << (SEL_BITS - 1));
  end

  // One-hot decode; an index >= NUM_CS matches nothing, giving a null transfer.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign cs_hit[gi] = (idx_shifted == SEL_BITS'(gi));
  end

  // A transfer drives SCLK/MOSI only when some chip-select is asserted.
  assign xfer_active = ~&cs_n_reg;

  // Next-state and datapath decode: update beats capture beats shift.
  always_comb begin
    state_next   = state_reg;
    cs_n_next    = cs_n_reg;
    clk_next     = clk_reg;
    mosi_next    = mosi_reg;
    tdo_next     = tdo_reg;
    cnt_next     = cnt_reg;
    phase_next   = phase_reg;
    hdr_cnt_next = hdr_cnt_reg;
    cs_idx_next  = cs_idx_reg;
    if (jtag_sel) begin
      if (jtag_update) begin
        cs_n_next  = '1;
        clk_next   = CPOL;
        phase_next = 1'b0;
        state_next = IDLE;
      end else if (jtag_capture) begin
        cs_n_next    = '1;
        clk_next     = CPOL;
        cnt_next     = '0;
        hdr_cnt_next = '0;
        cs_idx_next  = '0;
        state_next   = HDR;
      end else begin
        case (state_reg)
          HDR: begin
            if (jtag_shift) begin
              cs_idx_next  = idx_shifted;
              hdr_cnt_next = hdr_cnt_reg + 1'b1;
              if (hdr_cnt_reg == HDR_W'(SEL_BITS - 1)) begin
                state_next = XFER;
                phase_next = 1'b0;
                cs_n_next  = ~cs_hit;
              end
            end
          end
          XFER: begin
            if (jtag_shift) begin
              phase_next = ~phase_reg;
              if (!phase_reg) begin
                if (xfer_active) begin
                  mosi_next = jtag_tdi;
                  clk_next  = CPHA ? ~CPOL : CPOL;
                end
              end else begin
                if (xfer_active) begin
                  clk_next = CPHA ? CPOL : ~CPOL;
                end
                tdo_next = spi_miso;
                cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
              end
            end else begin
              // Pause: park SCLK and restart the bit on the next shift.
              clk_next   = CPOL;
              phase_next = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State register with asynchronous reset from the BSCAN RESET output.
  always_ff @(posedge jtag_tck or posedge jtag_reset) begin
    if (jtag_reset) begin
      state_reg   <= IDLE;
      cs_n_reg    <= '1;
      clk_reg     <= CPOL;
      mosi_reg    <= 1'b0;
      tdo_reg     <= 1'b0;
      cnt_reg     <= '0;
      phase_reg   <= 1'b0;
      hdr_cnt_reg <= '0;
      cs_idx_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cs_n_reg    <= cs_n_next;
      clk_reg     <= clk_next;
      mosi_reg    <= mosi_next;
      tdo_reg     <= tdo_next;
      cnt_reg     <= cnt_next;
      phase_reg   <= phase_next;
      hdr_cnt_reg <= hdr_cnt_next;
      cs_idx_reg  <= cs_idx_next;
    end
  end

  assign jtag_tdo  = tdo_reg;
  assign spi_clk   = clk_reg;
  assign spi_cs_n  = cs_n_reg;
  assign spi_mosi  = mosi_reg;
  assign bit_count = cnt_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_jtag_spi_bridge_mc.sv
// Scoreboard bench: five bridge instances (all CPOL/CPHA modes, plus a
// NUM_CS=3 / CNT_W=4 variant) share one scan stimulus. Expected transaction
// results are queued by the stimulus; a monitor acting as SPI slave pops and
// compares them whenever busy falls.
`timescale 1ns/1ps
module tb_jtag_spi_bridge_mc;
  localparam int NI = 5;
  localparam logic [NI-1:0] CPOL_V = 5'b01001;
  localparam logic [NI-1:0] CPHA_V = 5'b00101;

  logic tck = 1'b0;
  logic rst = 1'b1, sel = 1'b0, cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0, miso = 1'b0;
  always #5 tck = ~tck;

  logic [NI-1:0][3:0]  cs_a;
  logic [NI-1:0]       clk_a, mosi_a, tdo_a, busy_a;
  logic [NI-1:0][15:0] cnt_a;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NCS = (gi == 4) ? 3 : 4;
    localparam int CW  = (gi == 4) ? 4 : 16;
    logic [NCS-1:0] cs_n;
    logic [CW-1:0]  cnt;
    logic [3:0]     cs_pad;
    jtag_spi_bridge_mc #(.NUM_CS(NCS), .CPOL(CPOL_V[gi]), .CPHA(CPHA_V[gi]), .CNT_W(CW)) u_dut (
      .jtag_tck(tck), .jtag_reset(rst), .jtag_sel(sel), .jtag_capture(cap),
      .jtag_shift(sh), .jtag_update(upd), .jtag_tdi(tdi), .jtag_tdo(tdo_a[gi]),
      .spi_clk(clk_a[gi]), .spi_cs_n(cs_n), .spi_mosi(mosi_a[gi]), .spi_miso(miso),
      .bit_count(cnt), .busy(busy_a[gi]));
    always_comb begin
      cs_pad = '1;
      cs_pad[NCS-1:0] = cs_n;
    end
    assign cs_a[gi]  = cs_pad;
    assign cnt_a[gi] = 16'(cnt);
  end

  typedef struct {
    string               name;
    logic [NI-1:0][15:0] cnt;
    logic [NI-1:0][3:0]  mask;
    logic [NI-1:0][4:0]  edges;
    logic [NI-1:0][7:0]  mosi;
    logic [7:0]          tdo;
    bit                  chk;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, i, act, req);
    end
  endtask

  function automatic logic [23:0] outv(input int i);
    return {cs_a[i], clk_a[i], mosi_a[i], tdo_a[i], cnt_a[i], busy_a[i]};
  endfunction

  // Monitor / SPI slave model
  initial begin
    logic [NI-1:0]       clk_prev = CPOL_V;
    logic [NI-1:0][15:0] cnt_prev = '0;
    logic [NI-1:0][3:0]  mask_acc = '0;
    logic [NI-1:0][4:0]  lead_acc = '0, trail_acc = '0;
    logic [NI-1:0][7:0]  mosi_rx = '0, tdo_rx = '0;
    logic [NI-1:0][23:0] snap = '0;
    logic busy_prev = 1'b0, sel_prev = 1'b0, rst_prev = 1'b1;
    exp_t e;
    forever begin
      @(negedge tck);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          chk("rst_cs", i, 32'(cs_a[i]), 32'hF);
          chk("rst_clk", i, 32'(clk_a[i]), 32'(CPOL_V[i]));
          chk("rst_mosi", i, 32'(mosi_a[i]), 32'h0);
          chk("rst_tdo", i, 32'(tdo_a[i]), 32'h0);
          chk("rst_cnt", i, 32'(cnt_a[i]), 32'h0);
          chk("rst_busy", i, 32'(busy_a[i]), 32'h0);
        end else if (!sel_prev && !rst_prev) begin
          chk("sel_hold", i, 32'(outv(i)), 32'(snap[i]));
        end
        if (clk_a[i] !== clk_prev[i]) begin
          if (clk_prev[i] == CPOL_V[i]) begin
            lead_acc[i]++;
            if (!CPHA_V[i]) mosi_rx[i] = {mosi_rx[i][6:0], mosi_a[i]};
          end else begin
            trail_acc[i]++;
            if (CPHA_V[i]) mosi_rx[i] = {mosi_rx[i][6:0], mosi_a[i]};
          end
        end
        if (cnt_a[i] == cnt_prev[i] + 16'd1) tdo_rx[i] = {tdo_rx[i][6:0], tdo_a[i]};
        mask_acc[i] |= ~cs_a[i];
      end
      if (busy_prev && !busy_a[0]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: got busy fall with no expected transaction");
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < NI; i++) begin
            chk({e.name, "_cnt"}, i, 32'(cnt_a[i]), 32'(e.cnt[i]));
            chk({e.name, "_mask"}, i, 32'(mask_acc[i]), 32'(e.mask[i]));
            chk({e.name, "_csidle"}, i, 32'(cs_a[i]), 32'hF);
            chk({e.name, "_clkidle"}, i, 32'(clk_a[i]), 32'(CPOL_V[i]));
            chk({e.name, "_busy"}, i, 32'(busy_a[i]), 32'h0);
            if (e.chk) begin
              chk({e.name, "_lead"}, i, 32'(lead_acc[i]), 32'(e.edges[i]));
              chk({e.name, "_trail"}, i, 32'(trail_acc[i]), 32'(e.edges[i]));
              chk({e.name, "_mosi"}, i, 32'(mosi_rx[i]), 32'(e.mosi[i]));
              chk({e.name, "_tdo"}, i, 32'(tdo_rx[i]), 32'(e.tdo));
            end
          end
        end
        mask_acc = '0; lead_acc = '0; trail_acc = '0; mosi_rx = '0; tdo_rx = '0;
      end
      for (int i = 0; i < NI; i++) snap[i] = outv(i);
      clk_prev  = clk_a;
      cnt_prev  = cnt_a;
      busy_prev = busy_a[0];
      sel_prev  = sel;
      rst_prev  = rst;
    end
  end

  // Expected result of one scan for every instance
  task automatic push(input string nm, input int idx, input int nbits, input bit pause,
                      input bit chk_data, input logic [7:0] mo, input logic [7:0] mi);
    exp_t e;
    e.name = nm;
    e.tdo  = mi;
    e.chk  = chk_data;
    for (int i = 0; i < NI; i++) begin
      int ncs  = (i == 4) ? 3 : 4;
      int cmax = (i == 4) ? 15 : 65535;
      e.cnt[i]   = 16'((nbits > cmax) ? cmax : nbits);
      e.mask[i]  = (idx < ncs) ? 4'(1 << idx) : 4'h0;
      e.edges[i] = (idx < ncs) ? 5'(nbits + ((pause && CPHA_V[i]) ? 1 : 0)) : 5'd0;
      e.mosi[i]  = (idx < ncs) ? mo : 8'h00;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic s, input logic c, input logic h, input logic u,
                      input logic d, input logic m);
    sel = s; cap = c; sh = h; upd = u; tdi = d; miso = m;
    @(posedge tck);
    #2;
  endtask

  task automatic hdr(input int idx);
    logic [1:0] iv;
    iv = 2'(idx);
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, iv[0], 0);
    tick(1, 0, 1, 0, iv[1], 0);
  endtask

  // Top n bits of mo/mi, MSB first, each bit doubled
  task automatic bits(input logic [7:0] mo, input logic [7:0] mi, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1, 0, 1, 0, mo[7-k], mi[7-k]);
      tick(1, 0, 1, 0, mo[7-k], mi[7-k]);
    end
  endtask

  task automatic update();
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge tck);
    #2;
    rst = 1'b0;
    tick(1, 0, 0, 0, 0, 0);

    push("sel2", 2, 8, 0, 1, 8'hA5, 8'h3C);
    hdr(2); bits(8'hA5, 8'h3C, 8); update();

    push("null3", 3, 8, 0, 1, 8'h96, 8'hC3);
    hdr(3); bits(8'h96, 8'hC3, 8); update();

    push("pause", 1, 8, 1, 1, 8'hA5, 8'h3C);
    hdr(1);
    tick(1, 0, 1, 0, 1, 0);
    repeat (3) tick(1, 0, 0, 0, 1, 0);
    bits(8'hA5, 8'h3C, 8); update();

    push("selhold", 0, 4, 0, 0, 8'h00, 8'h00);
    hdr(0); bits(8'hF0, 8'h0F, 2);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      tick(0, (k == 2), kv[0], (k == 4), kv[1], kv[0]);
    end
    bits(8'h30, 8'hC0, 2); update();

    push("collide", 1, 3, 0, 0, 8'h00, 8'h00);
    hdr(1); bits(8'hA5, 8'h3C, 3);
    tick(1, 1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 1, 1);
    tick(1, 0, 1, 0, 0, 1);

    push("sat", 0, 20, 0, 0, 8'h00, 8'h00);
    hdr(0); bits(8'hFF, 8'h00, 8); bits(8'hFF, 8'h00, 8); bits(8'hFF, 8'h00, 4); update();

    push("rstmid", 2, 0, 0, 0, 8'h00, 8'h00);
    hdr(2); bits(8'hA5, 8'h3C, 5);
    rst = 1'b1;
    tick(1, 0, 1, 0, 1, 1);
    tick(1, 0, 1, 0, 1, 1);
    rst = 1'b0;
    repeat (3) tick(1, 0, 0, 0, 0, 0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
